// File: rtl/dff_pipe_if.sv
// Handshake/data bundle for dff_pipe: the producer side drives advance, flush and
// the qualified input word; the pipe returns its last stage and the occupancy count.
interface dff_pipe_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             en;
  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             q_valid;
  logic [CW-1:0]    count;

  modport master (output en, flush, in_valid, d, input  q, q_valid, count);
  modport slave  (input  en, flush, in_valid, d, output q, q_valid, count);
endinterface

// File: rtl/dff_pipe.sv
// WIDTH x DEPTH registered delay line with per-stage valid, advance enable, flush and
// occupancy count. Define DFF_PIPE_DATA_RST_EN to give the data stages reset/flush to RESET_VAL.
module dff_pipe_stage #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
`ifdef DFF_PIPE_DATA_RST_EN
  always_ff @(posedge clk) begin
    if (rst || flush) q <= RESET_VAL;
    else if (en)      q <= d;
  end
`else
  // enable-only flop: rst/flush merely suppress the shift so priority still holds
  always_ff @(posedge clk) begin
    if (en && !rst && !flush) q <= d;
  end
`endif
endmodule

module dff_pipe #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              CW        = $clog2(DEPTH + 1)
) (
  input logic         clk,
  input logic         rst,
  dff_pipe_if.slave   bus
);
  logic [DEPTH-1:0][WIDTH-1:0] data;
  logic [DEPTH-1:0]            vld_pipe;
  logic [CW-1:0]               cnt;
  logic [CW:0]                 cnt_nxt;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stg
    logic [WIDTH-1:0] stg_d;
    if (i == 0) begin : g_head
      assign stg_d = bus.d;
    end else begin : g_body
      assign stg_d = data[i-1];
    end
    dff_pipe_stage #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_stg (
      .clk   (clk),
      .rst   (rst),
      .flush (bus.flush),
      .en    (bus.en),
      .d     (stg_d),
      .q     (data[i])
    );
  end

  // one extra bit so an accounting slip shows up as a carry/borrow instead of wrapping
  always_comb begin
    cnt_nxt = {1'b0, cnt}
            + (CW+1)'(bus.en & bus.in_valid)
            - (CW+1)'(bus.en & vld_pipe[DEPTH-1]);
  end

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      vld_pipe <= '0;
      cnt      <= '0;
    end else if (bus.en) begin
      vld_pipe[0] <= bus.in_valid;
      for (int i = 1; i < DEPTH; i++) vld_pipe[i] <= vld_pipe[i-1];
      cnt <= cnt_nxt[CW-1:0];
    end
  end

  assign bus.q       = data[DEPTH-1];
  assign bus.q_valid = vld_pipe[DEPTH-1];
  assign bus.count   = cnt;

  a_cnt_range: assert property (@(posedge clk) disable iff (rst) !cnt_nxt[CW]);
  a_cnt_pop:   assert property (@(posedge clk) disable iff (rst) $countones(vld_pipe) == 32'(cnt));
endmodule

// File: tb/tb_dff_pipe.sv
// Directed vector table for the 8x4 pipe, plus a 1x1 build checked against a plain DFF.
module tb_dff_pipe;
  logic clk = 1'b0;
  logic rst, rst1;
  int   tests = 0;
  int   fails = 0;

`ifdef DFF_PIPE_DATA_RST_EN
  localparam bit RSTEN = 1'b1;
`else
  localparam bit RSTEN = 1'b0;
`endif

  always #5 clk = ~clk;

  dff_pipe_if #(.WIDTH(8), .DEPTH(4)) bus ();
  dff_pipe_if #(.WIDTH(1), .DEPTH(1)) bus1 ();

  dff_pipe #(.WIDTH(8), .DEPTH(4)) dut  (.clk(clk), .rst(rst),  .bus(bus.slave));
  dff_pipe #(.WIDTH(1), .DEPTH(1)) dut1 (.clk(clk), .rst(rst1), .bus(bus1.slave));

  // cq: 0 = don't check q, 1 = always check, 2 = check only when data reset is built in
  typedef struct {
    logic       r, f, e, v;
    logic [7:0] d;
    logic       ev;
    logic [2:0] ec;
    int         cq;
    logic [7:0] eq;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic r, f, e, v, input logic [7:0] d,
                     input logic ev, input logic [2:0] ec, input int cq, input logic [7:0] eq);
    vec_t t;
    t.r = r; t.f = f; t.e = e; t.v = v; t.d = d;
    t.ev = ev; t.ec = ec; t.cq = cq; t.eq = eq;
    tv.push_back(t);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  initial begin
    // reset
    add(1,0,0,0,8'h00, 0,0,2,8'h00);
    add(1,0,0,0,8'h00, 0,0,2,8'h00);
    // streaming 11..55 then drain
    add(0,0,1,1,8'h11, 0,1,0,8'h00);
    add(0,0,1,1,8'h22, 0,2,0,8'h00);
    add(0,0,1,1,8'h33, 0,3,0,8'h00);
    add(0,0,1,1,8'h44, 1,4,1,8'h11);
    add(0,0,1,1,8'h55, 1,4,1,8'h22);
    add(0,0,1,0,8'h00, 1,3,1,8'h33);
    add(0,0,1,0,8'h00, 1,2,1,8'h44);
    add(0,0,1,0,8'h00, 1,1,1,8'h55);
    add(0,0,1,0,8'h00, 0,0,0,8'h00);
    // stall: 3 cycles mid-fill (d/in_valid ignored), 2 cycles with output valid
    add(0,0,1,1,8'hA0, 0,1,0,8'h00);
    add(0,0,1,1,8'hA1, 0,2,0,8'h00);
    add(0,0,0,1,8'hEE, 0,2,0,8'h00);
    add(0,0,0,1,8'hEE, 0,2,0,8'h00);
    add(0,0,0,1,8'hEE, 0,2,0,8'h00);
    add(0,0,1,1,8'hA2, 0,3,0,8'h00);
    add(0,0,1,1,8'hA3, 1,4,1,8'hA0);
    add(0,0,1,0,8'h00, 1,3,1,8'hA1);
    add(0,0,0,1,8'hEE, 1,3,1,8'hA1);
    add(0,0,0,1,8'hEE, 1,3,1,8'hA1);
    add(0,0,1,0,8'h00, 1,2,1,8'hA2);
    add(0,0,1,0,8'h00, 1,1,1,8'hA3);
    add(0,0,1,0,8'h00, 0,0,0,8'h00);
    // bubbles
    add(0,0,1,1,8'h01, 0,1,0,8'h00);
    add(0,0,1,0,8'h02, 0,1,0,8'h00);
    add(0,0,1,1,8'h03, 0,2,0,8'h00);
    add(0,0,1,0,8'h04, 1,2,1,8'h01);
    add(0,0,1,0,8'h00, 0,1,0,8'h00);
    add(0,0,1,0,8'h00, 1,1,1,8'h03);
    add(0,0,1,0,8'h00, 0,0,0,8'h00);
    // flush with a word presented; FF must never emerge
    add(0,0,1,1,8'h10, 0,1,0,8'h00);
    add(0,0,1,1,8'h20, 0,2,0,8'h00);
    add(0,0,1,1,8'h30, 0,3,0,8'h00);
    add(0,0,1,1,8'h40, 1,4,1,8'h10);
    add(0,1,1,1,8'hFF, 0,0,2,8'h00);
    add(0,0,1,0,8'h00, 0,0,0,8'h00);
    add(0,0,1,0,8'h00, 0,0,0,8'h00);
    add(0,0,1,0,8'h00, 0,0,0,8'h00);
    add(0,0,1,0,8'h00, 0,0,0,8'h00);
    // reset on a full pipe
    add(0,0,1,1,8'h5A, 0,1,0,8'h00);
    add(0,0,1,1,8'h5B, 0,2,0,8'h00);
    add(0,0,1,1,8'h5C, 0,3,0,8'h00);
    add(0,0,1,1,8'h5D, 1,4,1,8'h5A);
    add(1,0,1,1,8'h77, 0,0,2,8'h00);
    add(0,0,1,0,8'h00, 0,0,0,8'h00);
    add(0,0,1,0,8'h00, 0,0,0,8'h00);
    add(0,0,1,0,8'h00, 0,0,0,8'h00);
    add(0,0,1,0,8'h00, 0,0,0,8'h00);
    add(0,0,1,1,8'h88, 0,1,0,8'h00);

    rst1 = 1'b1;
    bus1.en = 1'b0; bus1.flush = 1'b0; bus1.in_valid = 1'b0; bus1.d = 1'b0;

    foreach (tv[i]) begin
      rst          = tv[i].r;
      bus.flush    = tv[i].f;
      bus.en       = tv[i].e;
      bus.in_valid = tv[i].v;
      bus.d        = tv[i].d;
      @(posedge clk); #1;
      check($sformatf("v%0d.q_valid", i), 32'(bus.q_valid), 32'(tv[i].ev));
      check($sformatf("v%0d.count", i),   32'(bus.count),   32'(tv[i].ec));
      if (tv[i].cq == 1 || (tv[i].cq == 2 && RSTEN))
        check($sformatf("v%0d.q", i), 32'(bus.q), 32'(tv[i].eq));
    end

    // 1x1 build: reset state, then a plain DFF over random data
    check("d1.rst.q_valid", 32'(bus1.q_valid), 32'd0);
    check("d1.rst.count",   32'(bus1.count),   32'd0);
    rst1 = 1'b0; bus1.en = 1'b1; bus1.in_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      bus1.d = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      check($sformatf("d1.q[%0d]", k), 32'(bus1.q), 32'(bus1.d));
      if (k == 0 || k == 99) begin
        check($sformatf("d1.q_valid[%0d]", k), 32'(bus1.q_valid), 32'd1);
        check($sformatf("d1.count[%0d]", k),   32'(bus1.count),   32'd1);
      end
    end
    // simultaneous entry/exit keeps count; a bubble then empties the single stage
    bus1.in_valid = 1'b0;
    @(posedge clk); #1;
    check("d1.bubble.q_valid", 32'(bus1.q_valid), 32'd0);
    check("d1.bubble.count",   32'(bus1.count),   32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dff_pipe.md
# dff_pipe

Parametrised successor to the single-bit-of-state `dff`: a WIDTH-bit, DEPTH-stage registered delay line with per-stage valid tracking, global advance enable, synchronous flush and an occupancy count. It is the standard retiming/alignment element for datapaths where a bare flop no longer suffices, such as matching latency across parallel paths or stalling a short pipeline. With WIDTH=1, DEPTH=1, `en`=1 and `in_valid`=1 it behaves exactly as a plain D flip-flop.

## Interface
- WIDTH, 8, data width in bits (≥1)
- DEPTH, 4, number of register stages (≥1)
- RESET_VAL, '0, data reset value (used only with DFF_PIPE_DATA_RST_EN)
- CW, $clog2(DEPTH+1), count width (derived; not overridden)

- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- en  in  1  advance: all stages shift one position when high
- flush  in  1  synchronous clear of all valid bits
- in_valid  in  1  qualifies `d`
- d  in  WIDTH  input data
- q  out  WIDTH  data of last stage (DEPTH-1)
- q_valid  out  1  valid bit of last stage
- count  out  CW  number of stages currently holding valid data

## Operation
- State: data[0..DEPTH-1][WIDTH-1:0], vld[0..DEPTH-1], cnt[CW-1:0]; `q`=data[DEPTH-1], `q_valid`=vld[DEPTH-1], `count`=cnt, all direct register outputs.
- Priority per edge: rst > flush > en > hold.
- rst: vld all 0, cnt=0. Reset values: q_valid=0, count=0; q=RESET_VAL with macro, undefined without.
- flush (rst=0): vld all 0, cnt=0, regardless of en/in_valid; the incoming word is discarded. Data regs: RESET_VAL with macro, held without.
- en (rst=0, flush=0): data[0]<=d, vld[0]<=in_valid; data[i]<=data[i-1], vld[i]<=vld[i-1] for i≥1. Data shifts even when in_valid=0; bubbles travel as vld=0.
- Hold (en=0): all registers keep their values; d/in_valid ignored.
- count: cnt_next = cnt + (en & in_valid) − (en & vld[DEPTH-1]), computed in CW+1 bits; never exceeds DEPTH, never below 0. Equals popcount(vld) at all times; a mismatch is a design error.
- Simultaneous entry and exit (en, in_valid=1, q_valid=1): count unchanged.
- DEPTH=1: single stage; count is 1 bit.

## Timing
- Latency: a word accepted at edge N with en high on every following edge appears on q/q_valid after edge N+DEPTH−1, i.e. visible DEPTH cycles after d was presented.
- Each cycle with en=0 adds one cycle of latency to every in-flight word.
- flush/rst take effect at the edge they are sampled; outputs are cleared in the following cycle; no in-flight word emerges afterward.
- Throughput: one word per cycle when en=1.
- No combinational path from any input to any output.

## Configuration
- DFF_PIPE_DATA_RST_EN defined: rst and flush load RESET_VAL into every data stage; q is deterministic after reset/flush.
- Not defined: data registers have no reset or flush (enable-only flops for area); q is undefined after reset until a word reaches the last stage, and holds stale data after flush. Consumers must qualify q with q_valid. Valid and count behaviour is identical in both builds.

## Test plan
- Reset: rst=1 for 2 cycles, then 0 → q_valid=0, count=0; with macro q=8'h00.
- Streaming (W=8, D=4, en=1): drive 8'h11,22,33,44,55 with in_valid=1 on consecutive cycles → q=8'h11, q_valid=1 in the 4th cycle after 8'h11 presented, then 22..55 on consecutive cycles; count ramps 1,2,3,4 and holds 4.
- Stall: stream 8'hA0..A3, drop en for 3 cycles mid-stream → q/q_valid/count frozen; sequence resumes with latency +3, no loss or duplication.
- Bubbles: in_valid pattern 1,0,1,0 with d=8'h01..04 → q_valid pattern 1,0,1,0 with q=01,03 on valid cycles; count peaks at 2.
- Flush: fill 4 stages, assert flush together with en=1, in_valid=1, d=8'hFF → next cycle count=0, q_valid=0, 8'hFF never emerges; with macro q=RESET_VAL.
- Mid-operation reset and DEPTH=1: rst during a full pipe clears as in Reset; rebuild with W=1, D=1 and match a reference DFF cycle-for-cycle over 100 random d values.
